// File: rtl/prog_ctr_pkg.sv
// Shared constants and state type for the instruction-fetch program counter.
package prog_ctr_pkg;

  localparam int PC_W_DEF       = 10;
  localparam int START_ADDR_DEF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } pcState_t;

endpackage

// File: rtl/prog_ctr.sv
// Program counter: waits for a Start pulse, then steps by one per clock or loads a branch target.
// Latency: one cycle from decision edge to ProgCtr/Running. Backpressure: none, advances every clock in RUN.
// Optional macro RELBRANCH_EN adds the flag-conditioned relative branch input BranchRel.
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic            ALU_flag,
`ifdef RELBRANCH_EN
  input  logic            BranchRel,
`endif
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  pcState_t        state;
  pcState_t        nextState;
  logic [PC_W-1:0] nextPc;
  logic            takeRel;

`ifdef RELBRANCH_EN
  assign takeRel = BranchRel & ALU_flag;
`else
  logic unusedAluFlag;
  assign unusedAluFlag = ALU_flag;
  assign takeRel       = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      ProgCtr <= START_PC;
      Running <= 1'b0;
    end else begin
      state   <= nextState;
      ProgCtr <= nextPc;
      Running <= (nextState == RUN);
    end
  end

  // Start always wins; Branch beats the relative branch; plain adds wrap naturally.
  always_comb begin
    nextState = state;
    nextPc    = ProgCtr;
    unique case (state)
      IDLE: begin
        if (Start) begin
          nextState = ARMED;
          nextPc    = START_PC;
        end
      end
      ARMED: begin
        nextPc = START_PC;
        if (!Start) nextState = RUN;
      end
      RUN: begin
        if (Start) begin
          nextState = ARMED;
          nextPc    = START_PC;
        end else if (Branch) begin
          nextPc = Target;
        end else if (takeRel) begin
          nextPc = ProgCtr + Target;
        end else begin
          nextPc = ProgCtr + 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
        nextPc    = START_PC;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_ctr.sv
// Directed plus random checks of prog_ctr against an arithmetic reference model.
module tb_prog_ctr;

  localparam int PC_W = 10;
  localparam int MASK = (1 << PC_W) - 1;

  logic            Clk;
  logic            Reset;
  logic            Start;
  logic            Branch;
  logic            ALU_flag;
  logic            BranchRel;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;
  logic            Running;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = waiting for Start, 1 = held by Start, 2 = executing.
  int mPhase = 0;
  int mPc    = 0;

  prog_ctr #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Branch   (Branch),
    .ALU_flag (ALU_flag),
`ifdef RELBRANCH_EN
    .BranchRel(BranchRel),
`endif
    .Target   (Target),
    .ProgCtr  (ProgCtr),
    .Running  (Running)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelEdge();
    bit relOk;
`ifdef RELBRANCH_EN
    relOk = (BranchRel == 1'b1) && (ALU_flag == 1'b1);
`else
    relOk = 1'b0;
`endif
    case (mPhase)
      0: if (Start) begin mPhase = 1; mPc = 0; end
      1: begin mPc = 0; if (!Start) mPhase = 2; end
      default: begin
        if (Start) begin mPhase = 1; mPc = 0; end
        else if (Branch) mPc = int'(Target);
        else if (relOk) mPc = (mPc + int'(Target)) & MASK;
        else mPc = (mPc + 1) & MASK;
      end
    endcase
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    modelEdge();
    #1;
    chk({tag, ".pc"}, 32'(ProgCtr), 32'(mPc));
    chk({tag, ".run"}, 32'(Running), (mPhase == 2) ? 32'd1 : 32'd0);
  endtask

  task automatic drive(input logic s, input logic b, input logic a, input logic r, input int t);
    Start     = s;
    Branch    = b;
    ALU_flag  = a;
    BranchRel = r;
    Target    = PC_W'(t);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1 Reset = 1'b0;
    #2;
    chk("reset.pc", 32'(ProgCtr), 32'd0);
    chk("reset.run", 32'(Running), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b1;
    #1;
    chk("release.pc", 32'(ProgCtr), 32'd0);

    tick("idle_hold");
    drive(0, 1, 0, 0, 10);
    tick("idle_branch");
    drive(1, 0, 0, 0, 0);
    tick("start");
    drive(1, 1, 1, 0, 10);
    tick("armed_branch");
    drive(0, 0, 0, 0, 0);
    tick("armed_exit");
    tick("first_inc");
    drive(0, 1, 0, 0, 10);
    tick("branch_abs");
    drive(0, 0, 0, 0, 10);
    tick("after_branch");
`ifdef RELBRANCH_EN
    drive(0, 0, 0, 1, 5);
    tick("rel_noflag");
    drive(0, 0, 1, 1, 5);
    tick("rel_flag");
    drive(0, 0, 1, 1, 10'h3FD);
    tick("rel_neg");
    drive(0, 1, 1, 1, 100);
    tick("abs_over_rel");
`endif
    drive(0, 1, 0, 0, MASK);
    tick("to_top");
    drive(0, 0, 0, 0, 0);
    tick("wrap");
    drive(1, 1, 0, 0, 7);
    tick("restart");
    drive(0, 0, 0, 0, 0);
    tick("rerun");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom), int'($urandom_range(0, MASK)));
      tick("rand");
    end

    drive(0, 0, 0, 0, 0);
    repeat (3) tick("pre_abort");
    #3 Reset = 1'b0;
    #1;
    chk("abort.pc", 32'(ProgCtr), 32'd0);
    chk("abort.run", 32'(Running), 32'd0);
    mPhase = 0;
    mPc    = 0;
    @(negedge Clk) Reset = 1'b1;
    tick("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_ctr.md
Name: prog_ctr

Overview:
- Instruction-fetch program counter for the basic processor.
- Holds the index of the next instruction to fetch.
- Waits for a Start pulse after reset, then advances by one per clock or loads a branch target.
- Sits between the control decoder (Branch, Target) and instruction memory (ProgCtr feeds the address).

Parameters:
PC_W, 10, width of program counter and Target.
START_ADDR, 0, address loaded on reset and on Start; first instruction executed.

Ports:
Clk  input  1  single clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-low reset (asserted when 0).
Start  input  1  request to (re)start the program; level, sampled on Clk.
Branch  input  1  take branch this cycle (absolute, unconditional).
ALU_flag  input  1  ALU condition flag; used only with RELBRANCH_EN.
Target  input  PC_W  absolute branch target (relative offset with RELBRANCH_EN).
ProgCtr  output  PC_W  registered next-instruction index.
Running  output  1  high while in RUN state.

Behaviour:
- Reset low: ProgCtr=START_ADDR, state=IDLE, Running=0, immediately and independent of Clk. Release is synchronised by the first active edge.
- States are IDLE, ARMED and RUN. All transitions occur on the Clk rising edge.
- IDLE:
  - ProgCtr held.
  - Branch ignored.
  - Start=1 -> ARMED, ProgCtr=START_ADDR.
- ARMED:
  - ProgCtr held at START_ADDR while Start=1.
  - Start=0 -> RUN. ProgCtr stays START_ADDR on this edge, so the first instruction is START_ADDR.
  - Branch ignored.
- RUN, priority highest first:
  - Start=1 -> ARMED, ProgCtr=START_ADDR.
  - Else Branch=1 -> ProgCtr=Target, regardless of ALU_flag.
  - Else ProgCtr=ProgCtr+1.
- Increment wraps modulo 2^PC_W: all-ones -> 0.
- Running = (state==RUN), registered.
- Latency: a decision at edge N is visible on ProgCtr after edge N. No combinational input-to-output path.
- Reset mid-run aborts immediately to IDLE / START_ADDR.
- X on Branch while in RUN is treated as don't-care for synthesis. The bench never drives X.

Optional Feature:
Macro RELBRANCH_EN.
- Defined:
  - Adds input BranchRel (1 bit).
  - In RUN, if Branch=0 and BranchRel=1 and ALU_flag=1: ProgCtr = ProgCtr + Target. Target is a two's-complement signed offset; the sum wraps modulo 2^PC_W.
  - If BranchRel=1 and ALU_flag=0: normal +1.
  - Branch has priority over BranchRel.
- Not defined: no BranchRel port; ALU_flag is unused and tied off internally without warnings.

Decomposition:
- Package prog_ctr_pkg holds:
  - the default PC width constant (10);
  - the START_ADDR default;
  - the state enum typedef (IDLE, ARMED, RUN).
- Next-PC selection is a small combinational block inside prog_ctr. No sub-module is required.
- If shared with other fetch logic, it may be split out as pc_next_sel (inputs: state, Start, Branch, BranchRel, ALU_flag, Target, ProgCtr; output: next PC).

Test Plan:
- Reset low one cycle, then high -> ProgCtr=0, Running=0; with Start=0 for one more edge ProgCtr stays 0.
- Start=1 one edge -> ProgCtr=0. Start=0 next edge -> ProgCtr=0, Running=1. Next edge -> ProgCtr=1.
- In RUN at PC=1: Branch=1, Target=10 with ALU_flag=0 -> ProgCtr=10. Branch=0 next edge -> 11.
- In RUN at PC=1023, no branch -> ProgCtr=0 (wrap). Start=1 mid-run -> ProgCtr=0, Running=0. Reset low mid-cycle -> ProgCtr=0 asynchronously.
- RELBRANCH_EN at PC=11:
  - BranchRel=1, Target=5, ALU_flag=0 -> 12.
  - Then ALU_flag=1 -> 17.
  - Then Target=-3 (10'h3FD), ALU_flag=1 -> 14.
- Branch in IDLE or ARMED (Target=10) -> ignored, ProgCtr remains 0.
